// File: rtl/fifo_wr_rr_arbiter_if.sv
// Bundle of the requester side and FIFO write side of the round-robin write arbiter.
// The master modport is the arbiter's view; slave is the producers/FIFO view.
interface fifo_wr_rr_arbiter_if #(
  parameter int N_amisha = 4,
  parameter int B_amisha = 8
);
  logic [N_amisha-1:0]          req_amisha;
  logic [N_amisha*B_amisha-1:0] w_data_in_amisha;
  logic                         fifo_full_amisha;
  logic [N_amisha-1:0]          gnt_amisha;
  logic [N_amisha-1:0]          ack_amisha;
  logic                         fifo_wr_amisha;
  logic [B_amisha-1:0]          fifo_w_data_amisha;
  logic                         busy_amisha;

  modport master (
    input  req_amisha, w_data_in_amisha, fifo_full_amisha,
    output gnt_amisha, ack_amisha, fifo_wr_amisha, fifo_w_data_amisha, busy_amisha
  );

  modport slave (
    output req_amisha, w_data_in_amisha, fifo_full_amisha,
    input  gnt_amisha, ack_amisha, fifo_wr_amisha, fifo_w_data_amisha, busy_amisha
  );
endinterface

// File: rtl/fifo_wr_rr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N requesters, granting
// bounded bursts and rotating priority past the last granted requester.
module fifo_wr_rr_arbiter #(
  parameter int N_amisha     = 4,
  parameter int B_amisha     = 8,
  parameter int BURST_amisha = 4,
  parameter int CW_amisha    = 3
) (
  input  logic                 clk_amisha,
  input  logic                 reset_amisha,
  fifo_wr_rr_arbiter_if.master bus
);
  localparam int PW = (N_amisha > 1) ? $clog2(N_amisha) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state, state_nxt;
  logic [PW-1:0]         rr_ptr, rr_ptr_nxt;
  logic [PW-1:0]         g_idx, g_idx_nxt, g_idx_inc;
  logic [PW-1:0]         sel_idx;
  logic                  sel_valid;
  logic [CW_amisha-1:0]  cnt, cnt_nxt;
  logic [N_amisha-1:0]   gnt, gnt_nxt;
  logic                  busy, busy_nxt;
  logic                  wr;
  logic                  release_grant;

  // Circular first-set search starting at rr_ptr.
  always_comb begin
    logic [PW-1:0] cand;
    int            idx;
    sel_valid = 1'b0;
    sel_idx   = rr_ptr;
    cand      = '0;
    idx       = 0;
    for (int k = 0; k < N_amisha; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_amisha) idx = idx - N_amisha;
      cand = PW'(idx);
      if (!sel_valid && bus.req_amisha[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign g_idx_inc = (g_idx == PW'(N_amisha - 1)) ? '0 : g_idx + 1'b1;

  // State register
  always_ff @(posedge clk_amisha) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset_amisha) begin
      state  <= IDLE;
      rr_ptr <= '0;
      g_idx  <= '0;
      cnt    <= '0;
      gnt    <= '0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      g_idx  <= g_idx_nxt;
      cnt    <= cnt_nxt;
      gnt    <= gnt_nxt;
      busy   <= busy_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    g_idx_nxt     = g_idx;
    cnt_nxt       = cnt;
    gnt_nxt       = gnt;
    busy_nxt      = busy;
    release_grant = 1'b0;
    unique case (state)
      IDLE: begin
        if (sel_valid) begin
          state_nxt = GRANT;
          g_idx_nxt = sel_idx;
          gnt_nxt   = N_amisha'(1) << sel_idx;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
        end
      end
      GRANT: begin
        release_grant = (wr && (cnt == CW_amisha'(BURST_amisha - 1))) ||
                        !bus.req_amisha[g_idx];
        if (release_grant) begin
          state_nxt  = IDLE;
          gnt_nxt    = '0;
          cnt_nxt    = '0;
          busy_nxt   = 1'b0;
          rr_ptr_nxt = g_idx_inc;
        end else if (wr) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: the write strobe never fires against a full FIFO.
  always_comb begin
    wr                     = (state == GRANT) && bus.req_amisha[g_idx] && !bus.fifo_full_amisha;
    bus.fifo_wr_amisha     = wr;
    bus.ack_amisha         = wr ? gnt : '0;
    bus.fifo_w_data_amisha = (state == GRANT) ? bus.w_data_in_amisha[g_idx*B_amisha +: B_amisha] : '0;
    bus.gnt_amisha         = gnt;
    bus.busy_amisha        = busy;
  end
endmodule

// File: tb/tb_fifo_wr_rr_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural arbiter model.
module tb_fifo_wr_rr_arbiter;
  localparam int N     = 4;
  localparam int B     = 8;
  localparam int BURST = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_wr_rr_arbiter_if #(.N_amisha(N), .B_amisha(B)) bus ();

  fifo_wr_rr_arbiter #(
    .N_amisha(N), .B_amisha(B), .BURST_amisha(BURST), .CW_amisha(3)
  ) dut (
    .clk_amisha  (clk),
    .reset_amisha(reset),
    .bus         (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the port, how many words it has written, next priority.
  bit m_valid = 0;
  bit m_busy  = 0;
  int m_owner = 0;
  int m_words = 0;
  int m_ptr   = 0;

  always @(negedge clk) begin
    logic [N-1:0] e_gnt, e_ack;
    logic         e_wr;
    logic [B-1:0] e_data;
    int           pick;
    e_gnt  = m_busy ? (N'(1) << m_owner) : '0;
    e_wr   = m_busy && bus.req_amisha[m_owner] && !bus.fifo_full_amisha;
    e_ack  = e_wr ? e_gnt : '0;
    e_data = m_busy ? bus.w_data_in_amisha[m_owner*B +: B] : '0;
    if (m_valid) begin
      check("model_gnt",  32'(bus.gnt_amisha),         32'(e_gnt));
      check("model_ack",  32'(bus.ack_amisha),         32'(e_ack));
      check("model_wr",   32'(bus.fifo_wr_amisha),     32'(e_wr));
      check("model_data", 32'(bus.fifo_w_data_amisha), 32'(e_data));
      check("model_busy", 32'(bus.busy_amisha),        32'(m_busy));
    end
    if (reset) begin
      m_valid = 1;
      m_busy  = 0;
      m_words = 0;
      m_ptr   = 0;
    end else if (!m_busy) begin
      pick = -1;
      for (int k = 0; k < N; k++)
        if (pick < 0 && bus.req_amisha[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
      if (pick >= 0) begin
        m_busy  = 1;
        m_owner = pick;
        m_words = 0;
      end
    end else begin
      if (e_wr) m_words++;
      if ((e_wr && m_words == BURST) || !bus.req_amisha[m_owner]) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    bus.req_amisha = '0;
    bus.fifo_full_amisha = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int wcnt;
    int ackc [N];
    logic [N-1:0] g_at [5];
    logic [N-1:0] g_exp [5];

    reset = 1'b1;
    bus.req_amisha = 4'b1111;
    bus.w_data_in_amisha = 32'h1122_3344;
    bus.fifo_full_amisha = 1'b0;

    // Reset held two cycles with all requesting
    step();
    step();
    @(negedge clk);
    check("rst_gnt",  32'(bus.gnt_amisha), 32'h0);
    check("rst_busy", 32'(bus.busy_amisha), 32'h0);
    check("rst_wr",   32'(bus.fifo_wr_amisha), 32'h0);
    check("rst_data", 32'(bus.fifo_w_data_amisha), 32'h0);
    step();
    reset = 1'b0;
    step();
    @(negedge clk);
    check("rst_first_gnt", 32'(bus.gnt_amisha), 32'h1);

    // Single requester 2, data A0..A7
    do_reset();
    bus.req_amisha = 4'b0100;
    wcnt = 0;
    bus.w_data_in_amisha[23:16] = 8'hA0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.fifo_wr_amisha) begin
        check("single_data", 32'(bus.fifo_w_data_amisha), 32'(8'hA0 + wcnt));
        wcnt++;
      end
      if (k == 1) check("single_gnt_c1", 32'(bus.gnt_amisha), 32'h4);
      if (k == 5) check("single_bubble", 32'(bus.gnt_amisha), 32'h0);
      if (k == 6) check("single_regnt",  32'(bus.gnt_amisha), 32'h4);
      step();
      bus.w_data_in_amisha[23:16] = 8'(8'hA0 + wcnt);
    end
    check("single_words", 32'(wcnt), 32'd8);
    bus.req_amisha = 4'b1001;
    step();
    @(negedge clk);
    check("single_ptr3", 32'(bus.gnt_amisha), 32'h8);

    // All requesting: order 0,1,2,3,0 with 4 acks each
    do_reset();
    bus.req_amisha = 4'b1111;
    for (int i = 0; i < N; i++) ackc[i] = 0;
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      if (k < 20)
        for (int i = 0; i < N; i++) if (bus.ack_amisha[i]) ackc[i]++;
      if (k % 5 == 1) g_at[k/5] = bus.gnt_amisha;
      step();
    end
    g_exp[0] = 4'b0001; g_exp[1] = 4'b0010; g_exp[2] = 4'b0100;
    g_exp[3] = 4'b1000; g_exp[4] = 4'b0001;
    for (int i = 0; i < N; i++) check($sformatf("all_ack%0d", i), 32'(ackc[i]), 32'd4);
    for (int i = 0; i < 5; i++) check($sformatf("all_order%0d", i), 32'(g_at[i]), 32'(g_exp[i]));

    // Full stall on requester 1 after 2 writes
    do_reset();
    bus.req_amisha = 4'b0010;
    wcnt = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k >= 3 && k <= 5) begin
        check("stall_wr",  32'(bus.fifo_wr_amisha), 32'h0);
        check("stall_ack", 32'(bus.ack_amisha), 32'h0);
        check("stall_gnt", 32'(bus.gnt_amisha), 32'h2);
      end
      if (k >= 6 && bus.fifo_wr_amisha) wcnt++;
      if (k == 8) check("stall_release", 32'(bus.gnt_amisha), 32'h0);
      step();
      if (k + 1 == 3) bus.fifo_full_amisha = 1'b1;
      if (k + 1 == 6) bus.fifo_full_amisha = 1'b0;
    end
    check("stall_more_words", 32'(wcnt), 32'd2);

    // Early drop by requester 3 with requester 0 pending
    do_reset();
    bus.req_amisha = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("drop_gnt", 32'(bus.gnt_amisha), 32'h8);
        check("drop_wr1", 32'(bus.fifo_wr_amisha), 32'h1);
      end
      if (k == 2) check("drop_nowr", 32'(bus.fifo_wr_amisha), 32'h0);
      if (k == 3) check("drop_idle", 32'(bus.gnt_amisha), 32'h0);
      if (k == 4) check("drop_wrap", 32'(bus.gnt_amisha), 32'h1);
      step();
      if (k + 1 == 2) bus.req_amisha = 4'b0001;
    end

    // Reset during requester 2's third write
    do_reset();
    bus.req_amisha = 4'b0100;
    wcnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 3) check("mid_wr3", 32'(bus.fifo_wr_amisha), 32'h1);
      if (k == 4) begin
        check("mid_gnt",  32'(bus.gnt_amisha), 32'h0);
        check("mid_busy", 32'(bus.busy_amisha), 32'h0);
        check("mid_wr",   32'(bus.fifo_wr_amisha), 32'h0);
      end
      if (k == 5) check("mid_regnt", 32'(bus.gnt_amisha), 32'h4);
      if (k >= 5 && k <= 8 && bus.fifo_wr_amisha) wcnt++;
      if (k == 9) check("mid_release", 32'(bus.gnt_amisha), 32'h0);
      step();
      if (k + 1 == 3) reset = 1'b1;
      if (k + 1 == 4) reset = 1'b0;
    end
    check("mid_full_burst", 32'(wcnt), 32'd4);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      step();
      if ($urandom_range(0, 3) == 0) bus.req_amisha = N'($urandom);
      bus.fifo_full_amisha = ($urandom_range(0, 3) == 0);
      bus.w_data_in_amisha = $urandom;
      reset = ($urandom_range(0, 199) == 0);
    end
    step();
    reset = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fifo_wr_rr_arbiter.md
Name: fifo_wr_rr_arbiter

Overview:
- Round-robin write arbiter that shares one FIFO write port (w_data / wr / full) among N requesters.
- Grants one requester at a time for a bounded burst of words, then rotates priority.
- Sits between N producer blocks and the FIFO write side. Its fifo_* outputs connect directly to the FIFO's wr/w_data inputs, and the FIFO's full output connects to fifo_full_amisha.

Parameters:
- N_amisha, 4, number of requesters (>=2).
- B_amisha, 8, data word width; must match the FIFO's data width.
- BURST_amisha, 4, maximum words accepted per grant (>=1).
- CW_amisha, 3, burst counter width; must satisfy 2**CW_amisha > BURST_amisha.

Ports:
- clk_amisha  input  1  single clock; all state updates on its rising edge.
- reset_amisha  input  1  synchronous, active-high reset.
- req_amisha  input  N_amisha  per-requester write request; bit i held while requester i has a word on its data slice.
- w_data_in_amisha  input  N_amisha*B_amisha  requester i data at bits [i*B_amisha +: B_amisha].
- fifo_full_amisha  input  1  FIFO full flag.
- gnt_amisha  output  N_amisha  registered one-hot grant; all-zero when idle.
- ack_amisha  output  N_amisha  combinational; bit i=1 when requester i's word is written this cycle.
- fifo_wr_amisha  output  1  combinational FIFO write strobe.
- fifo_w_data_amisha  output  B_amisha  data slice of the granted requester; all-zero when no grant.
- busy_amisha  output  1  registered; 1 while in GRANT state.

Behaviour:
- State: FSM {IDLE, GRANT}, rr_ptr (log2 N bits), g_idx (granted index), cnt (CW_amisha bits).
- Reset (synchronous, overrides all else):
  - state=IDLE, rr_ptr=0, cnt=0, gnt=0, busy=0.
  - Therefore fifo_wr=0, ack=0, fifo_w_data=0 in the cycle after reset is sampled.
- IDLE:
  - gnt=0, fifo_wr=0.
  - If req!=0, select the first set bit searching circularly from rr_ptr upward: rr_ptr, rr_ptr+1, ... wrapping at N-1 to 0.
  - Next cycle: state=GRANT, gnt=onehot(sel), g_idx=sel, cnt=0.
  - If req==0, remain in IDLE.
- GRANT:
  - fifo_wr = req[g_idx] & ~fifo_full.
  - ack = gnt when fifo_wr=1, else 0.
  - fifo_w_data = slice g_idx.
  - Each accepted word (fifo_wr=1) increments cnt.
  - Release condition: (fifo_wr & cnt==BURST-1) OR req[g_idx]==0.
  - On release, next cycle: state=IDLE, gnt=0, cnt=0, rr_ptr = (g_idx+1) mod N.
  - No release: gnt, g_idx and state are held.
- Latency:
  - req asserted in cycle t (state IDLE) → gnt in t+1.
  - First write in t+1 if the FIFO is not full.
  - One idle bubble cycle between consecutive grants. Maximum throughput is BURST words per BURST+1 cycles.
- Full stall: while fifo_full=1, fifo_wr=0, ack=0, cnt frozen, grant held indefinitely. No timeout.
- Requester drops req while granted: release with no write that cycle. Partial burst counts as the turn; rr_ptr still advances.
- Requests arriving in the same cycle as a release are evaluated in the following IDLE cycle against the updated rr_ptr.
- req bits of non-granted requesters have no effect during GRANT.
- fifo_w_data is driven only from the granted slice; other slices are ignored.
- The arbiter never asserts fifo_wr while fifo_full=1. The FIFO's own full guard is redundant, not relied upon.
- cnt arithmetic is unsigned. It never exceeds BURST-1, so no wrap.

Test Plan:
All scenarios use N=4, B=8, BURST=4.
- Reset: hold reset_amisha 2 cycles with req=4'b1111 → gnt=0, busy=0, fifo_wr=0, fifo_w_data=8'h00. After release, first grant is requester 0 (gnt=4'b0001).
- Single requester: only req[2]=1 held 12 cycles, data 8'hA0..8'hA7, full=0 →
  - gnt=4'b0100 one cycle after req.
  - fifo_wr high 4 consecutive cycles, then 1 idle cycle, then re-grant to 2.
  - 8 words written in 10 cycles; rr_ptr=3 after the first burst.
- All requesting: req=4'b1111 continuously, full=0 → grant order 0,1,2,3,0, each with 4 writes. Period 5 cycles per grant; each ack bit pulses exactly 4 times per 20 cycles.
- Full stall: requester 1 granted, after 2 writes full=1 for 3 cycles →
  - fifo_wr=0, ack=0, gnt=4'b0010 held, cnt=2 throughout.
  - After full=0, exactly 2 more writes, then release.
- Early drop: requester 3 granted, req[3] drops after 1 write with req[0]=1 pending → gnt=0 next cycle (IDLE), then gnt=4'b0001 (rr_ptr wrapped 3→0).
- Reset mid-burst: reset asserted during requester 2's 3rd write cycle → next cycle gnt=0, busy=0, fifo_wr=0. With req[2]=1 still held, regrant restarts at requester 0 priority and gives gnt=4'b0100 after 1 IDLE cycle, cnt=0.
